// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings and sizing for the hazard control unit and its scoreboard.
package hazard_control_unit_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FCNT_W = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    HCU_IDLE  = 1'b0,
    HCU_FLUSH = 1'b1
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_scoreboard.sv
// hcu_scoreboard: per-register count of issued-but-unretired writers, with
// busy lookups for both sources and a saturation lookup for the destination.
module hcu_scoreboard
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned NREG  = hazard_control_unit_pkg::NREG,
  parameter int unsigned CNT_W = hazard_control_unit_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_rd,
  input  logic             dec_en,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             busy_rs1,
  output logic             busy_rs2,
  output logic             sat_rd
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  // x0 is pinned to zero; an issue and a retire on the same register cancel out.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (!(inc_en && (inc_rd == REG_W'(r)) && dec_en && (dec_rd == REG_W'(r)))) begin
        if (inc_en && (inc_rd == REG_W'(r)) && (cnt_q[r] != CNT_MAX)) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (dec_en && (dec_rd == REG_W'(r)) && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last writer retiring this cycle is readable through the negedge regfile write.
  assign busy_rs1 = (cnt_q[rs1] != '0) &&
                    !((cnt_q[rs1] == CNT_ONE) && dec_en && (dec_rd == rs1));
  assign busy_rs2 = (cnt_q[rs2] != '0) &&
                    !((cnt_q[rs2] == CNT_ONE) && dec_en && (dec_rd == rs2));
  assign sat_rd   = (cnt_q[rd] == CNT_MAX);

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-side interlock: RAW/WAW-saturation stalls plus post-redirect flush sequencing.
// Optional HCU_PERF_CNT_EN adds Stall_Count / Flush_Count event counters.
module hazard_control_unit #(
  parameter int unsigned NREG         = hazard_control_unit_pkg::NREG,
  parameter int unsigned CNT_W        = hazard_control_unit_pkg::CNT_W,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Valid_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        Rs1_Valid_ID,
  input  logic        Rs2_Valid_ID,
  input  logic [4:0]  rd_ID,
  input  logic        Write_Enable_ID,
  input  logic        Write_Enable_WB,
  input  logic [4:0]  rd_WB,
  input  logic        Redirect_EX,
  output logic        Stall_IF,
  output logic        Stall_ID,
  output logic        Flush_IF_ID,
  output logic        MUX_ID_PM,
  output logic        Issue_ID
`ifdef HCU_PERF_CNT_EN
  ,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
`endif
);

  import hazard_control_unit_pkg::*;

  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit                USE_FSM      = (FLUSH_CYCLES > 1);

  hcu_state_e        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic busy_rs1, busy_rs2, sat_rd;
  logic raw, waw, in_flush, flushing, stall, bubble, issue;

  hcu_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk      (Clk),
    .rst_n    (Reset),
    .inc_en   (issue & Write_Enable_ID),
    .inc_rd   (rd_ID),
    .dec_en   (Write_Enable_WB),
    .dec_rd   (rd_WB),
    .rs1      (rs1_ID),
    .rs2      (rs2_ID),
    .rd       (rd_ID),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .sat_rd   (sat_rd)
  );

  // A redirect outranks any stall: the stalled instruction is on the wrong path.
  always_comb begin
    in_flush = (state_q == HCU_FLUSH);
    flushing = in_flush | Redirect_EX;
    raw      = (Rs1_Valid_ID & busy_rs1) | (Rs2_Valid_ID & busy_rs2);
    waw      = Write_Enable_ID & (rd_ID != REG_ZERO) & sat_rd;
    stall    = Valid_ID & (raw | waw) & ~flushing;
    bubble   = stall | flushing;
    issue    = Valid_ID & ~bubble;
  end

  assign Stall_IF    = stall;
  assign Stall_ID    = stall;
  assign Flush_IF_ID = flushing;
  assign MUX_ID_PM   = bubble;
  assign Issue_ID    = issue;

  // The redirect cycle is the first bubble, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      HCU_IDLE: begin
        if (Redirect_EX && USE_FSM) begin
          state_d = HCU_FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end
      end
      HCU_FLUSH: begin
        if (Redirect_EX) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q <= FCNT_W'(1)) begin
          state_d = HCU_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= HCU_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HCU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall);
    flush_cnt_d = flush_cnt_q + 32'(flushing);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: an in-flight write queue model predicts
// each cycle's control outputs; a negedge monitor pops and compares them.
module tb_hazard_control_unit;

  localparam int FLUSH_CYCLES = 2;
  localparam int SAT          = 3;

  logic       Clk, Reset;
  logic       Valid_ID, Rs1_Valid_ID, Rs2_Valid_ID, Write_Enable_ID, Write_Enable_WB, Redirect_EX;
  logic [4:0] rs1_ID, rs2_ID, rd_ID, rd_WB;
  logic       Stall_IF, Stall_ID, Flush_IF_ID, MUX_ID_PM, Issue_ID;
`ifdef HCU_PERF_CNT_EN
  logic [31:0] Stall_Count, Flush_Count;
`endif

  hazard_control_unit #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Valid_ID        (Valid_ID),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .Rs1_Valid_ID    (Rs1_Valid_ID),
    .Rs2_Valid_ID    (Rs2_Valid_ID),
    .rd_ID           (rd_ID),
    .Write_Enable_ID (Write_Enable_ID),
    .Write_Enable_WB (Write_Enable_WB),
    .rd_WB           (rd_WB),
    .Redirect_EX     (Redirect_EX),
    .Stall_IF        (Stall_IF),
    .Stall_ID        (Stall_ID),
    .Flush_IF_ID     (Flush_IF_ID),
    .MUX_ID_PM       (MUX_ID_PM),
    .Issue_ID        (Issue_ID)
`ifdef HCU_PERF_CNT_EN
    ,
    .Stall_Count     (Stall_Count),
    .Flush_Count     (Flush_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] inflight[$];
  int         flush_rem     = 0;
  int         model_stalls  = 0;
  int         model_flushes = 0;

  function automatic int pending(input logic [4:0] r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  function automatic bit busy(input logic [4:0] r, input logic wbe, input logic [4:0] dwb);
    int p = pending(r);
    return (r != 5'd0) && (p > 0) && !((p == 1) && wbe && (dwb == r));
  endfunction

  // Monitor: one expected control vector per cycle, compared mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e, a;
      e = exp_q.pop_front();
      a = {Stall_IF, Stall_ID, Flush_IF_ID, MUX_ID_PM, Issue_ID};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctrl t=%0t {stallIF,stallID,flush,mux,issue} got %b expected %b", $time, a, e);
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] a1, input logic e1,
                      input logic [4:0] a2, input logic e2, input logic [4:0] d,
                      input logic we, input logic wbe, input logic [4:0] dwb,
                      input logic redir);
    logic raw, waw, stall, infl, mux, iss;
    @(posedge Clk); #1;
    Valid_ID = v; rs1_ID = a1; Rs1_Valid_ID = e1; rs2_ID = a2; Rs2_Valid_ID = e2;
    rd_ID = d; Write_Enable_ID = we; Write_Enable_WB = wbe; rd_WB = dwb; Redirect_EX = redir;
    infl  = (flush_rem > 0);
    raw   = (e1 && busy(a1, wbe, dwb)) || (e2 && busy(a2, wbe, dwb));
    waw   = we && (d != 5'd0) && (pending(d) >= SAT);
    stall = v && (raw || waw) && !infl && !redir;
    mux   = stall || infl || redir;
    iss   = v && !mux;
    exp_q.push_back({stall, stall, redir || infl, mux, iss});
    if (stall) model_stalls++;
    if (redir || infl) model_flushes++;
    if (wbe && (dwb != 5'd0)) begin
      for (int i = 0; i < inflight.size(); i++) begin
        if (inflight[i] == dwb) begin
          inflight.delete(i);
          break;
        end
      end
    end
    if (iss && we && (d != 5'd0)) inflight.push_back(d);
    if (redir) flush_rem = FLUSH_CYCLES - 1;
    else if (flush_rem > 0) flush_rem--;
  endtask

  task automatic idle(input logic wbe, input logic [4:0] dwb, input logic redir);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, wbe, dwb, redir);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [4:0] a;
    a = {Stall_IF, Stall_ID, Flush_IF_ID, MUX_ID_PM, Issue_ID};
    n_checks++;
    if (a !== 5'b0) begin
      n_fail++;
      $display("FAIL %s outputs got %b expected 00000", name, a);
    end
  endtask

  task automatic zero_inputs();
    Valid_ID = 0; rs1_ID = 0; Rs1_Valid_ID = 0; rs2_ID = 0; Rs2_Valid_ID = 0;
    rd_ID = 0; Write_Enable_ID = 0; Write_Enable_WB = 0; rd_WB = 0; Redirect_EX = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic v, e1, e2, we, wbe, redir;
    logic [4:0] a1, a2, d, dwb;
    Reset = 1'b0;
    zero_inputs();
    #12;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // RAW on x5: stall until the producer retires, no stall in the WB cycle
    step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 5'd0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 5'd0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 5'd0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 1, 5'd5, 0);
    idle(1, 5'd6, 0);
    // same-cycle retire of x7 while ID reads it
    step(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
    step(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 1, 5'd7, 0);
    idle(1, 5'd8, 0);
    step(1, 5'd7, 1, 5'd8, 1, 5'd0, 0, 0, 5'd0, 0);
    // four writers to x3: the fourth waits for a retire
    repeat (5) step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'd0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 5'd3, 0);
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'd0, 0);
    repeat (3) idle(1, 5'd3, 0);
    // redirect pulse
    idle(0, 5'd0, 1);
    step(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 5'd0, 0);
    step(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 5'd0, 0);
    step(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 0);
    // redirect squashes a RAW-stalled writer of x10
    step(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0);
    step(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 5'd0, 0);
    step(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 5'd0, 1);
    idle(0, 5'd0, 0);
    idle(1, 5'd9, 0);
    step(1, 5'd10, 1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0);
    // x0 is never tracked
    repeat (4) step(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
    idle(1, 5'd0, 0);
    // reset while flushing and with a pending writer
    step(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 5'd0, 0);
    idle(0, 5'd0, 1);
    @(posedge Clk); #1;
    zero_inputs();
    Reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_flush");
`ifdef HCU_PERF_CNT_EN
    n_checks++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got %0d/%0d expected 0/0", Stall_Count, Flush_Count);
    end
`endif
    inflight.delete();
    flush_rem = 0; model_stalls = 0; model_flushes = 0;
    @(negedge Clk);
    Reset = 1'b1;
    step(1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);

    // randomized traffic; retires come back in issue order
    for (int c = 0; c < 3000; c++) begin
      v     = ($urandom_range(0, 9) < 8);
      a1    = 5'($urandom_range(0, 7));
      a2    = 5'($urandom_range(0, 7));
      e1    = ($urandom_range(0, 3) != 0);
      e2    = ($urandom_range(0, 1) != 0);
      d     = 5'($urandom_range(0, 7));
      we    = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 15) == 0);
      if (inflight.size() > 0 && $urandom_range(0, 1) == 0) begin
        wbe = 1'b1;
        dwb = inflight[0];
      end else begin
        wbe = (inflight.size() == 0) && ($urandom_range(0, 7) == 0);
        dwb = wbe ? 5'd0 : 5'($urandom_range(0, 31));
      end
      step(v, a1, e1, a2, e2, d, we, wbe, dwb, redir);
    end
    @(posedge Clk); #1;
    zero_inputs();
    @(negedge Clk); #1;
`ifdef HCU_PERF_CNT_EN
    n_checks++;
    if (Stall_Count !== 32'(model_stalls) || Flush_Count !== 32'(model_flushes)) begin
      n_fail++;
      $display("FAIL perf_counts got %0d/%0d expected %0d/%0d",
               Stall_Count, Flush_Count, model_stalls, model_flushes);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
